// File: rtl/mmio_serial_tx.sv
// Memory-mapped UART transmitter: byte stores to the serial register are queued in a
// circular FIFO and shifted out as 8N1 frames, LSB first, with a registered line output.
module mmio_serial_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mmio_serial_en,
    input  logic                     mmio_wen,
    input  logic [7:0]               mmio_be_n,
    input  logic [63:0]              mmio_write_data,
    output logic                     uart_txd,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    drop_q;
    logic          push_req, push_ok, pop, drop;
    logic          unused_data;

    assign unused_data = ^mmio_write_data[63:8];

    assign push_req  = mmio_serial_en & mmio_wen & (|mmio_be_n);
    assign pop       = (state_q == StIdle) && (count_q != '0);
    assign fifo_full = (count_q == (AW+1)'(DEPTH));
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && !push_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            if (drop && (drop_q != 8'hff)) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= mmio_write_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d = StStart;
                    timer_d = '0;
                    shift_d = mem[rptr_q];
                end
            end
            StStart: begin
                if (timer_q == TIMER_MAX) begin
                    state_d = StData;
                    timer_d = '0;
                    bit_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StData: begin
                if (timer_q == TIMER_MAX) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStop: begin
                if (timer_q == TIMER_MAX) begin
                    state_d = StIdle;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is decoded from the next state so the flop shows it on the same edge.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[bit_d];
            default: txd_d = 1'b1;
        endcase
    end

    assign uart_txd   = txd_q;
    assign tx_busy    = (state_q != StIdle) || (count_q != '0);
    assign fifo_count = count_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_mmio_serial_tx.sv
// Bench for mmio_serial_tx: directed stores feed a byte scoreboard that a UART line
// monitor drains, plus direct checks on occupancy, drops, latency and reset behaviour.
module tb_mmio_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        wen = 1'b0;
    logic [7:0]  be  = 8'h00;
    logic [63:0] wdata = '0;
    logic        txd, busy, full;
    logic [2:0]  count;
    logic [7:0]  dcnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    mmio_serial_tx #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mmio_serial_en (en),
        .mmio_wen       (wen),
        .mmio_be_n      (be),
        .mmio_write_data(wdata),
        .uart_txd       (txd),
        .tx_busy        (busy),
        .fifo_count     (count),
        .fifo_full      (full),
        .drop_cnt       (dcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; the store lands on the next rising edge.
    task automatic wr(input logic [7:0] d, input logic w, input logic [7:0] lanes,
                      input bit accept);
        en    = 1'b1;
        wen   = w;
        be    = lanes;
        wdata = {56'hc0ffee_1234_5678, d};
        if (accept) sb.push_back(d);
        @(posedge clk);
        #1;
        en  = 1'b0;
        wen = 1'b0;
        be  = 8'h00;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    // Line monitor: decodes each frame and checks every bit holds for exactly CPB cycles.
    initial begin : monitor
        logic [9:0] lvl;
        bit ok, abort, gap_chk;
        int idle;
        gap_chk = 0;
        idle    = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                gap_chk = 0;
                idle    = 0;
            end else if (txd === 1'b1) begin
                idle++;
            end else begin
                if (gap_chk) check("interframe_gap", idle, 1);
                ok    = 1;
                abort = 0;
                lvl   = '0;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst) begin
                            abort = 1;
                            break;
                        end
                        if (c == 0) lvl[b] = txd;
                        else if (txd !== lvl[b]) ok = 0;
                    end
                end
                idle    = 0;
                gap_chk = 0;
                if (!abort) begin
                    check("frame_shape", {29'd0, ok, lvl[0], lvl[9]}, 32'b101);
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_frame: got byte 0x%0h required no frame",
                                 lvl[8:1]);
                    end else begin
                        total--;
                        check("frame_byte", lvl[8:1], sb.pop_front());
                        gap_chk = (sb.size() > 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit acc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd",   txd,   1);
        check("rst_busy",  busy,  0);
        check("rst_count", count, 0);
        check("rst_full",  full,  0);
        check("rst_drop",  dcnt,  0);
        rst = 1'b1;

        // Single frame of 0x55: latency and busy fall.
        wr(8'h55, 1'b1, 8'h01, 1);
        check("lat_e0", {txd, busy, count}, {1'b1, 1'b1, 3'd1});
        @(posedge clk);
        #1;
        check("lat_e1_txd",   txd,   0);
        check("lat_e1_count", count, 0);
        repeat (39) @(posedge clk);
        #1;
        check("stop_last_busy", {txd, busy}, 2'b11);
        @(posedge clk);
        #1;
        check("busy_fall", busy, 0);
        repeat (5) @(posedge clk);
        #1;

        // Accesses that must not push.
        wr(8'h77, 1'b0, 8'hff, 0);
        wr(8'h78, 1'b1, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        check("noop_count", count, 0);
        check("noop_txd",   txd,   1);
        check("noop_busy",  busy,  0);

        // Six back-to-back stores, then a store on the pop edge while full.
        for (int i = 1; i <= 6; i++) wr(8'(i), 1'b1, 8'(1 << (i % 8)), i <= 5);
        check("burst_count", count, 4);
        check("burst_full",  full,  1);
        check("burst_drop",  dcnt,  1);
        repeat (36) @(posedge clk);
        #1;
        check("prepop_count", count, 4);
        wr(8'hA5, 1'b1, 8'h80, 1);
        check("pushpop_count", count, 4);
        check("pushpop_drop",  dcnt,  1);
        drain("burst");

        // Reset in the middle of data bit 3 with two bytes queued.
        wr(8'h00, 1'b1, 8'h01, 1);
        wr(8'h3c, 1'b1, 8'h02, 1);
        wr(8'hc3, 1'b1, 8'h10, 1);
        check("prerst_count", count, 2);
        repeat (15) @(posedge clk);
        #1;
        check("prerst_txd", txd, 0);
        #2;
        rst = 1'b0;
        sb.delete();
        #1;
        check("midrst_txd",   txd,   1);
        check("midrst_count", count, 0);
        check("midrst_busy",  busy,  0);
        check("midrst_full",  full,  0);
        check("midrst_drop",  dcnt,  0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        wr(8'h5a, 1'b1, 8'h04, 1);
        check("post_rst_push", count, 1);
        drain("post_rst");

        // Heavy overflow: accepted only while filling or on each pop edge (every 41 cycles).
        for (int i = 0; i < 300; i++) begin
            acc = (i < 5) || (i >= 42 && ((i - 1) % 41) == 0);
            wr(8'(i), 1'b1, 8'(1 << (i % 8)), acc);
        end
        check("ovf_full", full, 1);
        check("ovf_drop", dcnt, 255);
        drain("ovf");
        check("ovf_drop_hold", dcnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_serial_tx.md
MMIO_SERIAL_TX -- requirements
Module: mmio_serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clocks per UART bit; legal values are 2 or more.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the TX FIFO entry count; legal values are powers of 2, 2 or more.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 mmio_serial_en  in  1  serial register selected (addr 0xa00003f8, any byte lane enabled).
REQ-006 mmio_wen  in  1  write qualifier for the current access.
REQ-007 mmio_be_n  in  8  byte-lane enables, active-high despite the suffix.
REQ-008 mmio_write_data  in  64  store data, byte right-aligned in bits [7:0].
REQ-009 uart_txd  out  1  serial line, 8N1, LSB first, idle high.
REQ-010 tx_busy  out  1  high while the FIFO is non-empty or a frame is in progress.
REQ-011 fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 fifo_full  out  1  high when fifo_count == DEPTH.
REQ-013 drop_cnt  out  8  count of writes discarded on overflow, saturating.

Function
REQ-014 A push request SHALL exist on every rising edge where mmio_serial_en=1, mmio_wen=1 and |mmio_be_n=1; each such cycle is one push.
REQ-015 The pushed byte SHALL be mmio_write_data[7:0] regardless of which lane is enabled.
REQ-016 The FIFO SHALL be a circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-017 Ordering SHALL be first-in, first-out.
REQ-018 A push when full with no pop on the same edge SHALL be dropped, leaving FIFO contents and pointers unchanged, and SHALL increment drop_cnt.
REQ-019 drop_cnt SHALL saturate at 255.
REQ-020 A push and a pop on the same edge SHALL both take effect, leaving fifo_count unchanged; when full, this push SHALL be accepted.
REQ-021 The transmit FSM SHALL have the states IDLE, START, DATA and STOP, with a bit-timer counting 0..CLKS_PER_BIT-1 and a bit index counting 0..7.
REQ-022 IDLE: uart_txd=1; on an edge where fifo_count>0, the FSM SHALL pop the head into the shift register, clear the timer and enter START.
REQ-023 START: uart_txd=0 for CLKS_PER_BIT cycles, then the FSM SHALL enter DATA with bit index 0.
REQ-024 DATA: uart_txd=shift[bit index] for CLKS_PER_BIT cycles per bit; after bit 7 the FSM SHALL enter STOP.
REQ-025 STOP: uart_txd=1 for CLKS_PER_BIT cycles, then the FSM SHALL enter IDLE.
REQ-026 A frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-027 Back-to-back frames SHALL be separated by exactly one IDLE cycle, so the line is high for CLKS_PER_BIT+1 cycles between frames.
REQ-028 Latency: a push at edge E0 into an empty FIFO with the FSM in IDLE SHALL drive uart_txd low starting from edge E0+1.
REQ-029 uart_txd SHALL be a registered output, glitch-free.
REQ-030 tx_busy SHALL equal (state != IDLE) || (fifo_count != 0).
REQ-031 Reads (mmio_wen=0) SHALL have no effect on this block.

Reset
REQ-032 While rst=0, the block SHALL immediately and asynchronously set uart_txd=1, tx_busy=0, fifo_count=0, fifo_full=0, drop_cnt=0, state IDLE, and pointers, timer and bit index to 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame, returning the line high at once, and SHALL discard all queued bytes.
REQ-034 After rst deasserts, the block SHALL accept a push on the first rising edge.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-035 Single write of 0x55 to an idle block: uart_txd SHALL be 0 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks; tx_busy SHALL fall one cycle after the stop bit ends.
REQ-036 Six consecutive write cycles of 0x01..0x06, one per clock, to an idle block: bytes 0x01..0x05 SHALL be transmitted in order, since 0x01 is popped the edge after its push; 0x06 SHALL be dropped with drop_cnt=1; fifo_count SHALL peak at 4 with fifo_full=1.
REQ-037 With the FIFO full and the FSM popping on the same edge as a write of 0xA5: fifo_count SHALL stay 4, drop_cnt SHALL not change, and 0xA5 SHALL be transmitted last.
REQ-038 A write with mmio_wen=0, or with mmio_be_n=0x00: fifo_count SHALL stay 0 and uart_txd SHALL stay 1.
REQ-039 rst asserted during DATA bit 3 with 2 bytes queued: uart_txd SHALL be 1 immediately, fifo_count=0, and no further frame SHALL be sent.
REQ-040 300 overflowing pushes: drop_cnt SHALL saturate at 255, and the FIFO pointers SHALL wrap correctly over more than 2*DEPTH accepted bytes.
